// File: rtl/hazard_sched_if.sv
// D-stage hazard information and scheduler control outputs for hazard_sched.
// HAZ_STATS_EN adds the stall_cnt statistics output.
interface hazard_sched_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic [4:0]  d_wba;
  logic [1:0]  d_tnew;
  logic        d_md_use;
  logic        d_md_start;
  logic        d_md_div;
  logic        pc_en;
  logic        fd_en;
  logic        de_clr;
  logic        md_busy;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wba, d_tnew,
           d_md_use, d_md_start, d_md_div,
    input  pc_en, fd_en, de_clr, md_busy, stall_cnt
  );
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wba, d_tnew,
           d_md_use, d_md_start, d_md_div,
    output pc_en, fd_en, de_clr, md_busy, stall_cnt
  );
`else
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wba, d_tnew,
           d_md_use, d_md_start, d_md_div,
    input  pc_en, fd_en, de_clr, md_busy
  );
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wba, d_tnew,
           d_md_use, d_md_start, d_md_div,
    output pc_en, fd_en, de_clr, md_busy
  );
`endif
endinterface

// File: rtl/hazard_sched.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline (Tuse/Tnew + mult/div busy).
// Optional HAZ_STATS_EN adds a free-running 32-bit stall cycle counter.
module hazard_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  hazard_sched_if.slave bus
);

  logic [4:0] wba_e_q,  wba_e_d;
  logic [1:0] tnew_e_q, tnew_e_d;
  logic       mds_e_q,  mds_e_d;
  logic       mdd_e_q,  mdd_e_d;
  logic [4:0] wba_m_q,  wba_m_d;
  logic [1:0] tnew_m_q, tnew_m_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic rs_haz_s;
  logic rt_haz_s;
  logic md_haz_s;
  logic md_busy_s;
  logic stall_s;

  // Hazard detection: a source hazards only if its producer's result arrives after it is needed.
  always_comb begin
    rs_haz_s = (bus.d_rs != 5'd0) &&
               (((bus.d_rs == wba_e_q) && (bus.d_tuse_rs < tnew_e_q)) ||
                ((bus.d_rs == wba_m_q) && (bus.d_tuse_rs < tnew_m_q)));
    rt_haz_s = (bus.d_rt != 5'd0) &&
               (((bus.d_rt == wba_e_q) && (bus.d_tuse_rt < tnew_e_q)) ||
                ((bus.d_rt == wba_m_q) && (bus.d_tuse_rt < tnew_m_q)));
    md_busy_s = mds_e_q || (md_cnt_q != 4'd0);
    md_haz_s  = bus.d_md_use && md_busy_s;
    stall_s   = rs_haz_s || rt_haz_s || md_haz_s;
  end

  // Next-state for the E/M shadows and the mult/div countdown.
  always_comb begin
    wba_e_d  = 5'd0;
    tnew_e_d = 2'd0;
    mds_e_d  = 1'b0;
    mdd_e_d  = 1'b0;
    if (stall_s) begin
      wba_e_d  = 5'd0;
      tnew_e_d = 2'd0;
      mds_e_d  = 1'b0;
      mdd_e_d  = 1'b0;
    end else begin
      wba_e_d  = bus.d_wba;
      tnew_e_d = bus.d_tnew;
      mds_e_d  = bus.d_md_start;
      mdd_e_d  = bus.d_md_div;
    end

    wba_m_d = wba_e_q;
    if (tnew_e_q == 2'd0) begin
      tnew_m_d = 2'd0;
    end else begin
      tnew_m_d = tnew_e_q - 2'd1;
    end

    // The load happens while the op sits in E, so busy spans start cycle + N.
    if (mds_e_q) begin
      md_cnt_d = mdd_e_q ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else begin
      md_cnt_d = 4'd0;
    end
  end

  // Shadow pipeline state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wba_e_q  <= 5'd0;
      tnew_e_q <= 2'd0;
      mds_e_q  <= 1'b0;
      mdd_e_q  <= 1'b0;
      wba_m_q  <= 5'd0;
      tnew_m_q <= 2'd0;
      md_cnt_q <= 4'd0;
    end else begin
      wba_e_q  <= wba_e_d;
      tnew_e_q <= tnew_e_d;
      mds_e_q  <= mds_e_d;
      mdd_e_q  <= mdd_e_d;
      wba_m_q  <= wba_m_d;
      tnew_m_q <= tnew_m_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Enables must act in the same cycle as the hazard, so they stay combinational.
  assign bus.pc_en   = ~stall_s;
  assign bus.fd_en   = ~stall_s;
  assign bus.de_clr  = stall_s;
  assign bus.md_busy = md_busy_s;

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall statistics; wraps naturally at 2^32.
  always_comb begin
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall statistics register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed-vector bench for hazard_sched: load-use, load-branch, $0, mult/div busy, reset abort.
module tb_hazard_sched;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hazard_sched_if bus_if ();

  hazard_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic stall, input logic busy);
    chk({tag, ".pc_en"},   {31'd0, bus_if.pc_en},   {31'd0, ~stall});
    chk({tag, ".fd_en"},   {31'd0, bus_if.fd_en},   {31'd0, ~stall});
    chk({tag, ".de_clr"},  {31'd0, bus_if.de_clr},  {31'd0, stall});
    chk({tag, ".md_busy"}, {31'd0, bus_if.md_busy}, {31'd0, busy});
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tuse_rs,
                       input logic [4:0] rt, input logic [1:0] tuse_rt,
                       input logic [4:0] wba, input logic [1:0] tnew,
                       input logic md_use, input logic md_start, input logic md_div);
    bus_if.d_rs       = rs;
    bus_if.d_tuse_rs  = tuse_rs;
    bus_if.d_rt       = rt;
    bus_if.d_tuse_rt  = tuse_rt;
    bus_if.d_wba      = wba;
    bus_if.d_tnew     = tnew;
    bus_if.d_md_use   = md_use;
    bus_if.d_md_start = md_start;
    bus_if.d_md_div   = md_div;
    #2;
  endtask

  task automatic idle();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle();
    tick();
    tick();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      idle();
      expect_ctl("idle", 1'b0, 1'b0);
      tick();
    end

    // Load-use: lw $8 then addu rs=8 tuse=1 -> exactly one stall
    set_d(5'd8, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("lu.c0.de_clr", {31'd0, bus_if.de_clr}, 32'd0);
    tick();
    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_ctl("lu.c1", 1'b1, 1'b0);
    tick();
    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_ctl("lu.c2", 1'b0, 1'b0);
    tick();
    flush();

    // Load-branch: lw $9 then beq rs=9 tuse=0 -> two stalls
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_d(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_ctl("lb.stall", 1'b1, 1'b0);
      tick();
    end
    set_d(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_ctl("lb.go", 1'b0, 1'b0);
    tick();
    flush();

    // $0 excluded: writer wba=0 tnew=2, reader rs=0 tuse=0
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_ctl("r0", 1'b0, 1'b0);
    tick();
    flush();

    // rt hazard: wba=12 tnew=2, reader rt=12 tuse=1 -> stall
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 2'd3, 5'd12, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rt.de_clr", {31'd0, bus_if.de_clr}, 32'd1);
    // Same producer, tuse=3 never hazards
    set_d(5'd12, 2'd3, 5'd12, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("tuse3.de_clr", {31'd0, bus_if.de_clr}, 32'd0);
    tick();
    flush();

    // tnew=0 writer is fully forwarded
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd13, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd13, 2'd0, 5'd13, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("tnew0.de_clr", {31'd0, bus_if.de_clr}, 32'd0);
    tick();
    flush();

    // mult then mflo: busy 6 cycles, mflo issues when busy falls
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    expect_ctl("mul.c0", 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      expect_ctl($sformatf("mul.busy%0d", i), 1'b1, 1'b1);
      tick();
    end
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    expect_ctl("mul.issue", 1'b0, 1'b0);
    tick();
    flush();

    // div, reset 3 cycles after it enters E -> no residual busy
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    chk("div.busy_e", {31'd0, bus_if.md_busy}, 32'd1);
    tick();
    tick();
    tick();
    chk("div.busy_t3", {31'd0, bus_if.md_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    expect_ctl("rst.abort", 1'b0, 1'b0);
    tick();
    flush();

`ifdef HAZ_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("stats.reset", bus_if.stall_cnt, 32'd0);
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 11; i++) begin
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("stats.de_clr", {31'd0, bus_if.de_clr}, 32'd0);
    chk("stats.cnt", bus_if.stall_cnt, 32'd11);
    tick();
    flush();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
